fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in the IF/ID register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low: sampled on the rising edge of clk, asserted when 0.
REQ-005 PCSrcE  input  1  redirect request from execute (taken branch/jump).
REQ-006 PCTargetE  input  32  redirect target address.
REQ-007 StallF  input  1  hold PC.
REQ-008 StallD  input  1  hold IF/ID register.
REQ-009 FlushD  input  1  replace IF/ID contents with a bubble.
REQ-010 IMemAddr  output  32  fetch address to instruction memory (word index = IMemAddr[31:2]).
REQ-011 IMemRD  input  32  instruction word returned combinationally by instruction memory for IMemAddr.
REQ-012 InstrD  output  32  registered instruction to decode.
REQ-013 PCD  output  32  registered PC of InstrD.
REQ-014 PCPlus4D  output  32  registered PCD+4.
REQ-015 ValidD  output  1  1 = InstrD is a real fetched instruction, 0 = bubble.

Function
REQ-016 PCF shall be a 32-bit register; IMemAddr shall equal PCF combinationally.
REQ-017 PCPlus4F shall be PCF+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000, no flag).
REQ-018 Next PC priority per edge: PCSrcE=1 -> {PCTargetE[31:2],2'b00}; else StallF=1 -> PCF held; else PCPlus4F.
REQ-019 PCSrcE shall override StallF in the same cycle; target bits [1:0] are forced to 0, no exception raised.
REQ-020 IF/ID register update priority per edge: FlushD=1 -> bubble; else StallD=1 -> hold all four D outputs; else load InstrD=IMemRD, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
REQ-021 Bubble: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-022 FlushD shall override StallD when both asserted.
REQ-023 PCSrcE=1 does not itself flush IF/ID; the hazard unit asserts FlushD alongside it.
REQ-024 Fetch latency: instruction at PCF appears on InstrD one edge later when StallD=0 and FlushD=0.
REQ-025 Stall consistency: StallF=1 with StallD=1 shall leave PCF and all D outputs unchanged for any number of cycles.
REQ-026 No combinational path from any input to InstrD/PCD/PCPlus4D/ValidD; IMemAddr depends only on PCF.

Reset
REQ-027 On a rising edge with rst=0: PCF=RESET_PC, D outputs set to bubble (REQ-021); rst overrides PCSrcE, StallF, StallD, FlushD.
REQ-028 Reset asserted mid-operation shall discard any pending redirect or stalled instruction; first real fetch is RESET_PC on the first edge after rst returns to 1.
REQ-029 While rst=0 instruction memory returns 0; that value shall never reach InstrD with ValidD=1.

Verification
REQ-030 Reset then run, memory holds 0x00500293,0x00300313,0x006283B3 at words 0..2 -> IMemAddr 0,4,8; InstrD 0x00500293 (PCD=0,ValidD=1), then 0x00300313 (PCD=4), then 0x006283B3 (PCD=8).
REQ-031 PCF=0x10, StallF=StallD=1 for 3 cycles -> PCF stays 0x10, InstrD/PCD unchanged; release -> PCF=0x14 next edge.
REQ-032 PCF=0x0C, PCSrcE=1, PCTargetE=0x00000006, FlushD=1, StallF=1 -> next edge PCF=0x04, InstrD=0x00000013, ValidD=0, PCD=0.
REQ-033 FlushD=1 and StallD=1 together -> bubble loaded, ValidD=0.
REQ-034 PCF=0xFFFFFFFC, no stall/redirect -> next PCF=0x00000000, PCPlus4D=0x00000000 with PCD=0xFFFFFFFC.
REQ-035 rst=0 asserted while StallD=1 with ValidD=1 and PCSrcE=1 -> next edge PCF=RESET_PC, ValidD=0, InstrD=0x00000013.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard-unit controls, instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  modport master (
    input  PCSrcE, PCTargetE, StallF, StallD, FlushD, IMemRD,
    output IMemAddr, InstrD, PCD, PCPlus4D, ValidD
  );

  modport slave (
    output PCSrcE, PCTargetE, StallF, StallD, FlushD, IMemRD,
    input  IMemAddr, InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register with redirect/stall priority feeding the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic [31:0] pc_next;

  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign bus.IMemAddr = pc_p0;

  // Redirect beats stall; the target is forced word-aligned without raising anything.
  always_comb begin
    pc_next = pc_plus4_p0;
    if (bus.PCSrcE)
      pc_next = bus.PCTargetE & ~32'd3;
    else if (bus.StallF)
      pc_next = pc_p0;
  end

  // F stage: program counter
  always_ff @(posedge clk) begin
    if (!rst)
      pc_p0 <= RESET_PC;
    else
      pc_p0 <= pc_next;
  end

  // F -> D boundary: reset and flush both load a bubble, flush beats stall
  always_ff @(posedge clk) begin
    if (!rst || bus.FlushD) begin
      bus.InstrD   <= NOP_INSTR;
      bus.PCD      <= 32'd0;
      bus.PCPlus4D <= 32'd0;
      bus.ValidD   <= 1'b0;
    end else if (!bus.StallD) begin
      bus.InstrD   <= bus.IMemRD;
      bus.PCD      <= pc_p0;
      bus.PCPlus4D <= pc_plus4_p0;
      bus.ValidD   <= 1'b1;
    end
  end

endmodule
